// File: rtl/player_ring_tracker_pkg.sv
// Shared types and defaults for the ring game position tracker.
package ring_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_LOAD = 2'd2,
    ST_PLAY = 2'd3
  } state_e;

  localparam int DEF_RING_LEN    = 24;
  localparam int DEF_NUM_PLAYERS = 4;

endpackage

// File: rtl/player_ring_tracker_btn_rise_det.sv
// Rising-edge detector: registers the previous button level and flags 0->1.
module btn_rise_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  logic btn_q;
  logic btn_d;

  // Previous-cycle button level; updates every cycle so a held button fires once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_d;
    end
  end

  // Next level and edge flag.
  always_comb begin
    btn_d  = btn_i;
    rise_o = btn_i & ~btn_q;
  end

endmodule

// File: rtl/player_ring_tracker.sv
// Tracks token positions on a circular board: even start spacing, turn order,
// move/lap/capture pulses for downstream scoring.
module player_ring_tracker
  import ring_game_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int RING_LEN    = DEF_RING_LEN,
  parameter int POS_W       = 5,
  parameter int STEP_W      = 3,
  parameter int IDX_W       = $clog2(NUM_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [3:0]                   n_active,
  input  logic                         btn,
  input  logic                         match,
  input  logic [STEP_W-1:0]            step,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_flat,
  output logic [IDX_W-1:0]             turn,
  output logic                         busy,
  output logic                         moved,
  output logic                         lap,
  output logic                         capture,
  output logic [IDX_W-1:0]             victim
);

  localparam logic [POS_W:0]   RING_LEN_C = (POS_W+1)'(RING_LEN);
  localparam logic [IDX_W:0]   NPL_C      = (IDX_W+1)'(NUM_PLAYERS);
  localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(NUM_PLAYERS - 1);

  state_e           state_q, state_d;
  logic [IDX_W:0]   nact_q, nact_d;
  logic [POS_W:0]   rem_q, rem_d;
  logic [POS_W:0]   quot_q, quot_d;
  logic [POS_W:0]   acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [POS_W-1:0] pos_q [NUM_PLAYERS];
  logic [POS_W-1:0] pos_d [NUM_PLAYERS];
  logic [IDX_W-1:0] turn_q, turn_d;
  logic             busy_q, busy_d;
  logic             moved_q, moved_d;
  logic             lap_q, lap_d;
  logic             capture_q, capture_d;
  logic [IDX_W-1:0] victim_q, victim_d;

  logic             rise_s;
  logic [POS_W:0]   nact_ext_s;
  logic             div_go_s;
  logic [IDX_W:0]   nact_clamp_s;
  logic [POS_W:0]   sum_s;
  logic [POS_W-1:0] new_pos_s;
  logic             wrap_s;
  logic [IDX_W:0]   turn_inc_s;
  logic             cap_hit_s;
  logic [IDX_W-1:0] cap_idx_s;

  btn_rise_det u_btn_rise_det (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_i  (btn),
    .rise_o (rise_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; start restarts from any state.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_DIV;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_DIV:  state_d = div_go_s ? ST_DIV : ST_LOAD;
        ST_LOAD: state_d = (idx_q == LAST_IDX_C) ? ST_PLAY : ST_LOAD;
        ST_PLAY: state_d = ST_PLAY;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shared arithmetic: clamp, division test, move sum and capture search.
  always_comb begin
    nact_ext_s = (POS_W+1)'(nact_q);
    div_go_s   = (rem_q >= nact_ext_s);
    if (n_active == 4'd0) begin
      nact_clamp_s = (IDX_W+1)'(1);
    end else if (int'(n_active) > NUM_PLAYERS) begin
      nact_clamp_s = NPL_C;
    end else begin
      nact_clamp_s = (IDX_W+1)'(n_active);
    end
    // Step is narrower than the ring, so one conditional subtract wraps.
    sum_s  = {1'b0, pos_q[turn_q]} + (POS_W+1)'(step);
    wrap_s = (sum_s >= RING_LEN_C);
    if (wrap_s) begin
      new_pos_s = POS_W'(sum_s - RING_LEN_C);
    end else begin
      new_pos_s = POS_W'(sum_s);
    end
    turn_inc_s = (IDX_W+1)'(turn_q) + (IDX_W+1)'(1);
    cap_hit_s  = 1'b0;
    cap_idx_s  = '0;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      if (!cap_hit_s && ((IDX_W+1)'(j) < nact_q) && (IDX_W'(j) != turn_q) &&
          (pos_q[j] == new_pos_s)) begin
        cap_hit_s = 1'b1;
        cap_idx_s = IDX_W'(j);
      end else begin
        cap_hit_s = cap_hit_s;
      end
    end
  end

  // Datapath and registered-output next values per FSM state.
  always_comb begin
    nact_d    = nact_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    turn_d    = turn_q;
    busy_d    = busy_q;
    moved_d   = 1'b0;
    lap_d     = 1'b0;
    capture_d = 1'b0;
    victim_d  = '0;
    if (start) begin
      nact_d = nact_clamp_s;
      rem_d  = RING_LEN_C;
      quot_d = '0;
      busy_d = 1'b1;
    end else begin
      case (state_q)
        ST_DIV: begin
          if (div_go_s) begin
            rem_d  = rem_q - nact_ext_s;
            quot_d = quot_q + (POS_W+1)'(1);
          end else begin
            acc_d = '0;
            idx_d = '0;
          end
        end
        ST_LOAD: begin
          pos_d[idx_q] = ((IDX_W+1)'(idx_q) < nact_q) ? POS_W'(acc_q) : '0;
          acc_d        = acc_q + quot_q;
          if (idx_q == LAST_IDX_C) begin
            idx_d  = '0;
            turn_d = '0;
            busy_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_PLAY: begin
          if (rise_s && match) begin
            pos_d[turn_q] = new_pos_s;
            moved_d       = 1'b1;
            lap_d         = wrap_s;
            capture_d     = cap_hit_s;
            victim_d      = cap_hit_s ? cap_idx_s : '0;
          end else if (rise_s) begin
            turn_d = (turn_inc_s == nact_q) ? '0 : IDX_W'(turn_inc_s);
          end else begin
            turn_d = turn_q;
          end
        end
        default: begin
          busy_d = busy_q;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      nact_q    <= (IDX_W+1)'(1);
      rem_q     <= '0;
      quot_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      turn_q    <= '0;
      busy_q    <= 1'b0;
      moved_q   <= 1'b0;
      lap_q     <= 1'b0;
      capture_q <= 1'b0;
      victim_q  <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pos_q[i] <= '0;
      end
    end else begin
      nact_q    <= nact_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      turn_q    <= turn_d;
      busy_q    <= busy_d;
      moved_q   <= moved_d;
      lap_q     <= lap_d;
      capture_q <= capture_d;
      victim_q  <= victim_d;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pos_q[i] <= pos_d[i];
      end
    end
  end

  // Output mapping.
  always_comb begin
    pos_flat = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      pos_flat[i*POS_W +: POS_W] = pos_q[i];
    end
    turn    = turn_q;
    busy    = busy_q;
    moved   = moved_q;
    lap     = lap_q;
    capture = capture_q;
    victim  = victim_q;
  end

endmodule

// File: doc/player_ring_tracker.md
Name: player_ring_tracker

Overview:
- Parametrised position tracker for NUM_PLAYERS tokens on a circular board of RING_LEN tiles.
- On game start it computes evenly spaced start tiles for the active player count, then tracks the current turn.
- On each qualified move button press it advances the active token, or passes the turn on a miss.
- Flags wrap-around (lap) and landing on an occupied tile (capture) for the scoring and display logic downstream.

Parameters:
- NUM_PLAYERS, 4, number of token slots; 2..8.
- RING_LEN, 24, tiles on the ring; positions 0..RING_LEN-1.
- POS_W, 5, position width; 2^POS_W >= RING_LEN.
- STEP_W, 3, width of the step amount; 2^STEP_W-1 < RING_LEN.
- IDX_W, $clog2(NUM_PLAYERS), player index width (derived).

Ports:
- clk, in, 1, system clock; all state changes on rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle strobe; (re)initialises the game.
- n_active, in, 4, active player count, sampled on start.
- btn, in, 1, move button level, already synchronised; rising edge detected internally.
- match, in, 1, current tile matched; sampled on the btn edge cycle.
- step, in, STEP_W, tiles to advance; sampled on the btn edge cycle.
- pos_flat, out, NUM_PLAYERS*POS_W, position of player i at bits [i*POS_W +: POS_W].
- turn, out, IDX_W, index of the player to move.
- busy, out, 1, high while initialising.
- moved, out, 1, one-cycle pulse: a token moved.
- lap, out, 1, one-cycle pulse: the move wrapped past tile RING_LEN-1.
- capture, out, 1, one-cycle pulse: the moved token landed on another active token.
- victim, out, IDX_W, lowest-index player captured; valid with capture, else 0.

Behaviour:
- Reset (rst=1):
  - all pos = 0, turn = 0, busy = 0, pulses = 0, victim = 0.
  - FSM goes to IDLE; btn edge register = 0.
  - rst overrides start and btn in the same cycle.
- FSM states: IDLE, DIV, LOAD, PLAY.
- IDLE, start=1:
  - latch nact = clamp(n_active, 1, NUM_PLAYERS); 0 maps to 1, values above NUM_PLAYERS map to NUM_PLAYERS.
  - set rem = RING_LEN, q = 0, busy = 1, go to DIV.
- DIV: each cycle, if rem >= nact then rem -= nact and q += 1; else go to LOAD with acc = 0, idx = 0.
- LOAD: each cycle, write pos[idx] = (idx < nact) ? acc : 0; acc += q; idx += 1. After idx = NUM_PLAYERS-1, go to PLAY, turn = 0, busy = 0.
- Remainder tiles are unused: with nact=3 and RING_LEN=24 the start tiles are 0, 8, 16; with nact=1 the start tile is 0.
- start in any state (DIV/LOAD/PLAY) restarts at the IDLE start action the same cycle.
- PLAY: a move event is a rising edge of btn, i.e. btn=1 and the previous-cycle btn=0.
  - The edge register updates every cycle in every state, so an edge during busy is consumed and not replayed.
- Move event, match=1:
  - sum = pos[turn] + step.
  - If sum >= RING_LEN, then new = sum - RING_LEN and lap = 1; else new = sum.
  - pos[turn] <= new; moved = 1 next cycle; turn unchanged.
  - step=0 still pulses moved with an unchanged position.
- Capture: if new equals pos[j] for any active j != turn, then capture = 1 and victim = lowest such j. Positions are not altered.
- Move event, match=0: turn <= (turn+1 == nact) ? 0 : turn+1; no pulse. With nact=1, turn stays 0.
- Pulse timing: moved, lap and capture are registered and assert exactly one cycle, in the cycle after the edge. They are 0 otherwise.
- Inactive players' positions are held at 0 and excluded from capture.
- Width rules: sum is computed at POS_W+1 bits; a single conditional subtract suffices given the step bound.

Decomposition:
- Package ring_game_pkg:
  - FSM state enum (IDLE/DIV/LOAD/PLAY).
  - Default RING_LEN=24, NUM_PLAYERS=4.
- One sub-module, btn_rise_det (registered rising-edge detector, sync reset).
- Division, load and move logic stay in the top level.

Test Plan:
- rst, then start with n_active=3 (RING_LEN=24, NUM_PLAYERS=4) -> busy high for 9 DIV + 4 LOAD cycles; pos = {0,8,16,0}, turn=0.
- From that state: btn edge, match=1, step=5 -> pos[0]=5, moved pulse 1 cycle, lap=0; turn stays 0.
- pos[2]=16: turn set to 2 via two match=0 edges, then match=1, step=7 -> pos[2]=23, lap=0. Next edge, step=3 -> pos[2]=2, lap=1.
- pos[0]=5, pos[1]=8: turn=0, match=1, step=3 -> pos[0]=8, capture=1, victim=1. Player 3 (inactive, pos 0) is never a victim.
- Turn wrap: nact=3, turn=2, match=0 -> turn=0. Hold btn high for 10 cycles -> exactly one move event.
- Mid-game start with n_active=0 -> clamps to 1, pos all 0, turn fixed 0. Then rst during DIV -> all outputs 0, state IDLE.
